ecc_core_arb: RTL and testbench
===============================

# ecc_core_arb

Arbiter and sequencer that shares one `ecc_core` instance between `NREQ` requesters (for example ECDHE, ECDSA and X25519 clients).
- Selects a requester by round-robin and registers its operands and mode.
- Pulses the core's `start`, then watches the core's `status` until completion, error or timeout.
- Returns the result, tagged with the requester index, over a valid/ready response channel.

It sits directly in front of `ecc_core` in the crypto subsystem. It is the only block permitted to drive the core's `din`, `mode` and `start`.

## Interface
Parameters:
- `WIDTH`, default 256: operand width, matching `ecc_core`.
- `NREQ`, default 3: number of requesters, 2..8.
- `IDW`, default 2: requester index width, ≥ clog2(NREQ).
- `TO_W`, default 20: width of the timeout counter; the timeout limit is 2^TO_W−1 cycles.

Ports (name, direction, width, meaning):
- `clk`  in  1  — clock.
- `rst`  in  1  — asynchronous, active-high reset.
- `req_valid`  in  NREQ  — per-requester command valid.
- `req_ready`  out  NREQ  — per-requester accept, one-hot or zero.
- `req_din`  in  NREQ*3*WIDTH  — packed operands; slot i is bits [i*3*WIDTH +: 3*WIDTH].
- `req_mode`  in  NREQ*3  — packed modes; slot i is bits [i*3 +: 3].
- `rsp_valid`  out  1  — response valid.
- `rsp_ready`  in  1  — response accept.
- `rsp_id`  out  IDW  — index of the requester that issued the command.
- `rsp_dout`  out  WIDTH  — captured core result.
- `rsp_err`  out  1  — command failed (core error, timeout or reserved mode).
- `core_din`  out  3*WIDTH  — to `ecc_core.din`.
- `core_mode`  out  3  — to `ecc_core.mode`.
- `core_start`  out  1  — to `ecc_core.start`.
- `core_rst`  out  1  — synchronous reset pulse to the core, used on timeout.
- `core_dout`  in  WIDTH  — from `ecc_core.dout`.
- `core_status`  in  2  — from `ecc_core.status`: 00 idle, 01 busy, 10 done/result valid, 11 error.

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- **IDLE**
  - Grant goes to the first requester with `req_valid` set, searching from `last_grant+1` modulo NREQ.
  - `req_ready[g]` is combinational: high only in IDLE and only for the granted index `g`.
  - On the handshake (`req_valid[g] & req_ready[g]`):
    - latch `req_din` slot g into `core_din` and `req_mode` slot g into `core_mode`;
    - set `rsp_id` to g and `last_grant` to g;
    - go to START.
  - Reserved mode 3'b111: the request is accepted, the core is not started, `rsp_err` is set to 1 and the FSM goes straight to RESP.
- **START**
  - `core_start` is high for exactly one cycle.
  - The timeout counter is cleared.
  - Go to WAIT.
- **WAIT**
  - `core_status` is sampled only in this state; any status seen during START is ignored.
  - 2'b10: capture `core_dout` into `rsp_dout`, set `rsp_err` to 0, go to RESP.
  - 2'b11: set `rsp_dout` to 0 and `rsp_err` to 1, go to RESP.
  - Counter reaches 2^TO_W−1:
    - `core_rst` is high for one cycle;
    - set `rsp_err` to 1, go to RESP.
  - Otherwise the counter increments, saturating at its limit.
- **RESP**
  - `rsp_valid` is high, with `rsp_id`, `rsp_dout` and `rsp_err` held stable.
  - On `rsp_ready`: go to IDLE.
  - No new command is accepted until the response has been consumed. There is exactly one outstanding command.
- `core_din` and `core_mode` hold their latched values from acceptance until the next acceptance, and do not change during WAIT.
- Requesters must keep `req_din` and `req_mode` stable while `req_valid` is high. Dropping `req_valid` before it is granted is legal; that requester is simply not selected.
- Reset values: every output is 0; `last_grant` is NREQ−1, so requester 0 wins first; state is IDLE.
- Reset mid-operation: the FSM returns to IDLE, any in-flight response is discarded, and `core_rst` is 0. The core is reset separately by the system `rst`.

## Timing
- Accepted at edge N, meaning the handshake occurs in cycle N−1:
  - START state, with `core_start` high, during cycle N to N+1;
  - WAIT from edge N+1.
- Core reports 10 in cycle M while in WAIT: `rsp_valid` is high from edge M+1.
- Arbitration overhead is 3 cycles plus the response handshake. Back-to-back: the next `req_ready` can be high in the cycle after the `rsp_valid & rsp_ready` edge.
- Reserved-mode command: `rsp_valid` is high 1 cycle after acceptance.
- Fairness: with all requesters constantly valid, each is granted once every NREQ commands.

## Test plan
- **Single command.** Requester 1 sends mode 3'b110 with u = e6db…1c4c and k = a546…9ac4. A behavioural core returns 10 after 50 cycles with dout = c3da…8552.
  - Required: `core_start` is a single pulse 1 cycle after acceptance.
  - Required: `rsp_valid` with `rsp_id`=1, that dout and `rsp_err`=0, 1 cycle after done.
- **Round-robin.** All 3 requesters are valid continuously for 6 commands.
  - Required: grant order 0,1,2,0,1,2.
  - Required: `req_ready` is never high outside IDLE.
- **Core error.** The model returns 11.
  - Required: `rsp_err`=1 and `rsp_dout`=0.
  - Required: the next request is accepted after `rsp_ready`.
- **Timeout** (run with TO_W=4). The core stays at 01.
  - Required: `core_rst` is a 1-cycle pulse 15 cycles into WAIT, followed by `rsp_err`=1.
- **Reserved mode and backpressure.**
  - Mode 3'b111: required `core_start` never asserts, and `rsp_err`=1 one cycle after acceptance.
  - Hold `rsp_ready`=0 for 10 cycles: required `rsp_valid` and its data stay stable, and no further grant occurs.
- **Reset mid-WAIT.** Assert `rst` 20 cycles into WAIT.
  - Required: all outputs are 0 immediately (asynchronous reset).
  - Required: after release, requester 0 is granted first.

Source files
------------

// File: rtl/ecc_core_arb.sv
// ecc_core_arb: round-robin front end that shares a single ecc_core between
// NREQ requesters. One command is in flight at a time. Each command is
// latched, started with a one-cycle pulse, and watched until the core
// reports done, error or a timeout. The result is then returned tagged with
// the requester index.
module ecc_core_arb #(
    parameter int WIDTH = 256,
    parameter int NREQ  = 3,
    parameter int IDW   = 2,
    parameter int TO_W  = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*3*WIDTH-1:0]    req_din,
    input  logic [NREQ*3-1:0]          req_mode,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [IDW-1:0]             rsp_id,
    output logic [WIDTH-1:0]           rsp_dout,
    output logic                       rsp_err,
    output logic [3*WIDTH-1:0]         core_din,
    output logic [2:0]                 core_mode,
    output logic                       core_start,
    output logic                       core_rst,
    input  logic [WIDTH-1:0]           core_dout,
    input  logic [1:0]                 core_status
);

    localparam int DW = 3 * WIDTH;
    localparam int SW = $clog2(NREQ);
    localparam logic [2:0] MODE_RSVD = 3'b111;
    localparam logic [1:0] ST_DONE = 2'b10;
    localparam logic [1:0] ST_ERR  = 2'b11;
    // The counter value one below its all-ones limit. The timeout fires on
    // the cycle in which the counter would reach the limit.
    localparam logic [TO_W-1:0] TO_MAX  = '1;
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    typedef struct packed {
        logic [DW-1:0] din;
        logic [2:0]    mode;
    } cmd_t;

    state_t              state;
    logic [IDW-1:0]      last_grant;
    logic [IDW-1:0]      gnt_idx;
    logic [SW-1:0]       gnt_sel;
    logic                gnt_any;
    logic [TO_W-1:0]     to_cnt;
    cmd_t [NREQ-1:0]     slot;

    // Unpack the flat request buses into one command record per requester.
    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        assign slot[i].din  = req_din[i*DW +: DW];
        assign slot[i].mode = req_mode[i*3 +: 3];
    end

    // Round-robin pick: first valid requester after last_grant, wrapping.
    always_comb begin
        int cand;
        cand    = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_sel = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!gnt_any && req_valid[SW'(cand)]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(cand);
                gnt_sel = SW'(cand);
            end
        end
    end

    // Ready goes only to the granted requester, and only while idle. It is
    // held low during reset so that every output reads zero under reset.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_any && !rst) req_ready[gnt_sel] = 1'b1;
    end

    // Command sequencer: accept, start, wait on status or timeout, respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDW'(NREQ - 1);
            to_cnt     <= '0;
            core_din   <= '0;
            core_mode  <= '0;
            core_start <= 1'b0;
            core_rst   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_dout   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            core_start <= 1'b0;
            core_rst   <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        core_din   <= slot[gnt_sel].din;
                        core_mode  <= slot[gnt_sel].mode;
                        rsp_id     <= gnt_idx;
                        last_grant <= gnt_idx;
                        if (slot[gnt_sel].mode == MODE_RSVD) begin
                            // Reserved mode never reaches the core.
                            rsp_dout  <= '0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            core_start <= 1'b1;
                            state      <= START;
                        end
                    end
                end
                START: begin
                    // Status is ignored here: it may still show the previous result.
                    to_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (core_status == ST_DONE) begin
                        rsp_dout  <= core_dout;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (core_status == ST_ERR) begin
                        rsp_dout  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (to_cnt == TO_LAST) begin
                        to_cnt    <= TO_MAX;
                        core_rst  <= 1'b1;
                        rsp_dout  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (to_cnt != TO_MAX) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_core_arb.sv
// Directed bench for ecc_core_arb. A table of commands runs against a small
// behavioural core. Hand-written sequences cover reset mid-WAIT, and the
// timeout path on a second instance built with a 4-bit timeout counter.
module tb_ecc_core_arb;

    localparam int W  = 256;
    localparam int DW = 3 * W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance
    logic [2:0]      req_valid = '0;
    logic [2:0]      req_ready;
    logic [3*DW-1:0] req_din;
    logic [8:0]      req_mode = '0;
    logic            rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [1:0]      rsp_id;
    logic [W-1:0]    rsp_dout;
    logic [DW-1:0]   core_din;
    logic [2:0]      core_mode;
    logic            core_start, core_rst;
    logic [W-1:0]    core_dout;
    logic [1:0]      core_status;

    // timeout instance
    logic [2:0]      req_valid2 = '0;
    logic [2:0]      req_ready2;
    logic [8:0]      req_mode2 = '0;
    logic            rsp_valid2, rsp_ready2 = 1'b0, rsp_err2;
    logic [1:0]      rsp_id2;
    logic [W-1:0]    rsp_dout2;
    logic [DW-1:0]   core_din2;
    logic [2:0]      core_mode2;
    logic            core_start2, core_rst2;
    logic [W-1:0]    core_dout2 = '1;
    logic [1:0]      core_status2 = 2'b01;

    ecc_core_arb #(.WIDTH(W), .NREQ(3), .IDW(2), .TO_W(20)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_din(req_din), .req_mode(req_mode), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_dout(rsp_dout),
        .rsp_err(rsp_err), .core_din(core_din), .core_mode(core_mode),
        .core_start(core_start), .core_rst(core_rst), .core_dout(core_dout),
        .core_status(core_status));

    ecc_core_arb #(.WIDTH(W), .NREQ(3), .IDW(2), .TO_W(4)) dut_to (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_din(req_din), .req_mode(req_mode2), .rsp_valid(rsp_valid2),
        .rsp_ready(rsp_ready2), .rsp_id(rsp_id2), .rsp_dout(rsp_dout2),
        .rsp_err(rsp_err2), .core_din(core_din2), .core_mode(core_mode2),
        .core_start(core_start2), .core_rst(core_rst2), .core_dout(core_dout2),
        .core_status(core_status2));

    localparam logic [W-1:0] U_IN  = 256'he6db6867583030db3594c1a424b15f7c726624ec26b3353b10a903a6d0ab1c4c;
    localparam logic [W-1:0] K_IN  = 256'ha546e36bf0527c9d3b16154b82465edd62144c0ac1fc5a18506a2244ba449ac4;
    localparam logic [W-1:0] R_OUT = 256'hc3da55379de9c6908e94ea4df28d084f32eccf03491c71f754b4075577a28552;

    logic [DW-1:0] din_tab [3];
    initial begin
        din_tab[0] = {3{256'h0123456789abcdef_0011223344556677_8899aabbccddeeff_f0e1d2c3b4a59687}};
        din_tab[1] = {256'd0, K_IN, U_IN};
        din_tab[2] = {3{256'hfedcba9876543210_7766554433221100_ffeeddccbbaa9988_1122334455667788}};
    end
    assign req_din = {din_tab[2], din_tab[1], din_tab[0]};

    // behavioural core: busy for plan_lat cycles after start, then reports plan_st
    int           plan_lat = 1;
    logic [1:0]   plan_st = 2'b10;
    logic [W-1:0] plan_dout = '0;
    int           m_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_status <= 2'b00;
            core_dout   <= '0;
            m_cnt       <= 0;
        end else if (core_rst) begin
            core_status <= 2'b00;
            m_cnt       <= 0;
        end else if (core_start) begin
            core_status <= 2'b01;
            m_cnt       <= plan_lat;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                core_status <= plan_st;
                core_dout   <= plan_dout;
            end
        end
    end

    // count start pulses on the main instance
    int n_start = 0;
    always @(posedge clk) if (core_start) n_start <= n_start + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]   mask;
        logic [2:0]   mode;
        int           lat;
        logic [1:0]   st;
        int           hold;
        logic [W-1:0] cdout;
        logic [1:0]   exp_id;
        logic         exp_err;
        logic [W-1:0] exp_dout;
    } vec_t;

    task automatic run_cmd(input vec_t v);
        int k, c, n0;
        logic bad, rsvd, e0;
        logic [W-1:0] d0;
        logic [1:0] id0;
        rsvd      = (v.mode == 3'b111);
        plan_lat  = v.lat;
        plan_st   = v.st;
        plan_dout = v.cdout;
        req_mode  = {3{v.mode}};
        req_valid = v.mask;
        n0 = n_start;
        k = 0;
        @(negedge clk);
        while (req_ready == 3'b000 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("ready_delay", k, 0);
        chk("grant", req_ready, 3'b001 << v.exp_id);
        @(posedge clk); #1;
        chk("core_din", core_din, din_tab[v.exp_id]);
        chk("core_mode", core_mode, v.mode);
        chk("start_pulse", core_start, !rsvd);
        bad = (req_ready != 3'b000);
        c = 0;
        while (!rsp_valid && c < v.lat + 40) begin
            @(posedge clk); #1;
            c++;
            if (req_ready != 3'b000) bad = 1'b1;
        end
        chk("rsp_latency", c, rsvd ? 0 : v.lat + 2);
        chk("din_held", core_din, din_tab[v.exp_id]);
        chk("rsp_id", rsp_id, v.exp_id);
        chk("rsp_err", rsp_err, v.exp_err);
        chk("rsp_dout", rsp_dout, v.exp_dout);
        d0 = rsp_dout; id0 = rsp_id; e0 = rsp_err;
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_dout !== d0 || rsp_id !== id0 || rsp_err !== e0 ||
                req_ready != 3'b000 || core_start) bad = 1'b1;
        end
        chk("busy_ready_or_unstable", bad, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_consumed", rsp_valid, 0);
        chk("start_count", n_start - n0, rsvd ? 0 : 1);
    endtask

    vec_t tab [10];

    initial begin
        int c;
        tab[0] = '{3'b111, 3'b001, 5,  2'b10, 0,  {8{32'h1111_0000}}, 2'd0, 1'b0, {8{32'h1111_0000}}};
        tab[1] = '{3'b111, 3'b010, 7,  2'b10, 0,  {8{32'h2222_0001}}, 2'd1, 1'b0, {8{32'h2222_0001}}};
        tab[2] = '{3'b111, 3'b011, 3,  2'b10, 0,  {8{32'h3333_0002}}, 2'd2, 1'b0, {8{32'h3333_0002}}};
        tab[3] = '{3'b111, 3'b100, 1,  2'b10, 0,  {8{32'h4444_0003}}, 2'd0, 1'b0, {8{32'h4444_0003}}};
        tab[4] = '{3'b111, 3'b101, 9,  2'b10, 0,  {8{32'h5555_0004}}, 2'd1, 1'b0, {8{32'h5555_0004}}};
        tab[5] = '{3'b111, 3'b110, 4,  2'b10, 0,  {8{32'h6666_0005}}, 2'd2, 1'b0, {8{32'h6666_0005}}};
        tab[6] = '{3'b010, 3'b110, 50, 2'b10, 0,  R_OUT,              2'd1, 1'b0, R_OUT};
        tab[7] = '{3'b100, 3'b010, 12, 2'b11, 0,  {8{32'hdead_beef}}, 2'd2, 1'b1, '0};
        tab[8] = '{3'b001, 3'b111, 0,  2'b00, 10, '0,                 2'd0, 1'b1, '0};
        tab[9] = '{3'b011, 3'b001, 6,  2'b10, 3,  {8{32'h9999_0009}}, 2'd1, 1'b0, {8{32'h9999_0009}}};

        // reset state, with requests pending to show ready is held low
        req_valid = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", {rsp_valid, req_ready, core_start, core_rst, rsp_id, rsp_err, core_mode}, 0);
        chk("rst_core_din", core_din, 0);
        chk("rst_rsp_dout", rsp_dout, 0);
        rst = 1'b0;
        req_valid = 3'b000;

        for (int i = 0; i < 10; i++) run_cmd(tab[i]);

        // reset mid-WAIT: requester 0 in flight, then reset with 0 and 1 pending
        plan_lat = 300; plan_st = 2'b10; plan_dout = '1;
        req_mode = {3{3'b001}};
        req_valid = 3'b001;
        @(negedge clk);
        chk("mid_rst_grant", req_ready, 3'b001);
        @(posedge clk); #1;
        req_valid = 3'b000;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        chk("mid_rst_in_wait", {rsp_valid, core_start}, 0);
        req_valid = 3'b011;
        rst = 1'b1;
        #1;
        chk("mid_rst_ctrl", {rsp_valid, req_ready, core_start, core_rst, rsp_id, rsp_err, core_mode}, 0);
        chk("mid_rst_core_din", core_din, 0);
        chk("mid_rst_rsp_dout", rsp_dout, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("grant_after_rst", req_ready, 3'b001);
        req_valid = 3'b000;
        @(posedge clk); #1;

        // timeout on the 4-bit counter instance: core stays busy forever
        req_mode2 = {3{3'b110}};
        req_valid2 = 3'b001;
        @(negedge clk);
        chk("to_grant", req_ready2, 3'b001);
        @(posedge clk); #1;
        req_valid2 = 3'b000;
        @(posedge clk);
        c = 0;
        while (!core_rst2 && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        chk("to_cycles_in_wait", c, 15);
        chk("to_rsp_valid", rsp_valid2, 1);
        chk("to_rsp_err", rsp_err2, 1);
        chk("to_rsp_id", rsp_id2, 0);
        @(posedge clk); #1;
        chk("to_rst_width", core_rst2, 0);
        chk("to_rsp_held", rsp_valid2, 1);
        rsp_ready2 = 1'b1;
        @(posedge clk); #1;
        rsp_ready2 = 1'b0;
        chk("to_rsp_consumed", rsp_valid2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench did not finish");
    end

endmodule
